prog_launcher: RTL and testbench

Host-side initiator for the processor's Start/Ack program handshake. On a `Go` request it runs `NUM_PROGS` programs back to back: for each one it pulses `DutStart`, waits for the processor's `Ack` to drop and then rise again, and reports that program's execution cycle count. It sits beside the processor top level in the lab harness, replacing hand-written testbench sequencing, and flags any program that never halts.

---
 rtl/prog_launcher_pkg.sv | 20 ++
 rtl/prog_launcher_cycle_counter.sv | 34 +++
 rtl/prog_launcher.sv | 142 ++++++++++++++
 tb/tb_prog_launcher.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_launcher_pkg.sv
// prog_launcher_pkg
//   Shared types and constants for the program launcher: the FSM state
//   enum, the run-counter width and the default run-phase timeout.
package prog_launcher_pkg;

  localparam int CYC_W = 16;

  localparam logic [CYC_W-1:0] DEF_MAX_CYCLES = 16'd50000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_LOW,
    ST_WAIT_HIGH,
    ST_RECORD,
    ST_DONE,
    ST_ERROR
  } launch_state_t;

endpackage

// File: rtl/prog_launcher_cycle_counter.sv
// cycle_counter
//   Saturating up-counter used to time a program's run phase.
//   Ports:
//     Clk, Reset  clock (posedge) and asynchronous active-high reset
//     clr         synchronous clear (wins over en)
//     en          count enable; the count holds at all-ones
//     count       current count
//     at_limit    high while count equals LIMIT
module cycle_counter
  import prog_launcher_pkg::*;
#(
  parameter logic [CYC_W-1:0] LIMIT = DEF_MAX_CYCLES
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             clr,
  input  logic             en,
  output logic [CYC_W-1:0] count,
  output logic             at_limit
);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + CYC_W'(1);
    end
  end

  assign at_limit = (count == LIMIT);

endmodule

// File: rtl/prog_launcher.sv
// prog_launcher
//   Host-side initiator for the processor Start/Ack handshake. On Go it runs
//   NUM_PROGS programs back to back: pulses DutStart for START_LEN cycles,
//   waits for DutAck to fall and then rise, and reports the run cycle count.
//   A program that does not finish within MAX_CYCLES aborts the sequence.
//   Ports:
//     Clk, Reset   clock (posedge) and asynchronous active-high reset
//     Go           start a sequence (honoured in IDLE, DONE, ERROR)
//     DutStart     processor Start
//     DutAck       processor Ack (halt decode)
//     ProgIdx      current / last finished program index
//     CycleCount   run cycles of the last finished (or timed-out) program
//     ResultValid  one-cycle pulse qualifying CycleCount / ProgIdx
//     Busy         sequence in progress
//     Done         whole sequence completed (level)
//     TimeoutErr   a program exceeded MAX_CYCLES (level)
module prog_launcher
  import prog_launcher_pkg::*;
#(
  parameter int               NUM_PROGS  = 3,
  parameter int               START_LEN  = 1,
  parameter logic [CYC_W-1:0] MAX_CYCLES = DEF_MAX_CYCLES,
  parameter int               PW         = $clog2(NUM_PROGS) + 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Go,
  output logic             DutStart,
  input  logic             DutAck,
  output logic [PW-1:0]    ProgIdx,
  output logic [CYC_W-1:0] CycleCount,
  output logic             ResultValid,
  output logic             Busy,
  output logic             Done,
  output logic             TimeoutErr
);

  localparam logic [PW-1:0] LAST_IDX   = PW'(NUM_PROGS - 1);
  localparam logic [15:0]   START_LAST = 16'(START_LEN - 1);

  launch_state_t    state;
  logic [15:0]      startCnt;
  logic [CYC_W-1:0] runCnt;
  logic             atLimit;
  logic             cntClr;
  logic             cntEn;

  // Counter is zeroed while Start is asserted and runs only in the wait states.
  assign cntClr = (state == ST_START);
  assign cntEn  = (state == ST_WAIT_LOW) || (state == ST_WAIT_HIGH);

  cycle_counter #(
    .LIMIT (MAX_CYCLES)
  ) u_runCounter (
    .Clk      (Clk),
    .Reset    (Reset),
    .clr      (cntClr),
    .en       (cntEn),
    .count    (runCnt),
    .at_limit (atLimit)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= ST_IDLE;
      startCnt    <= '0;
      DutStart    <= 1'b0;
      ProgIdx     <= '0;
      CycleCount  <= '0;
      ResultValid <= 1'b0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      TimeoutErr  <= 1'b0;
    end else begin
      ResultValid <= 1'b0;
      unique case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (Go) begin
            state      <= ST_START;
            startCnt   <= '0;
            ProgIdx    <= '0;
            Done       <= 1'b0;
            TimeoutErr <= 1'b0;
            DutStart   <= 1'b1;
            Busy       <= 1'b1;
          end
        end

        // Ack is deliberately ignored: the previous halt may still decode.
        ST_START: begin
          if (startCnt == START_LAST) begin
            state    <= ST_WAIT_LOW;
            DutStart <= 1'b0;
          end else begin
            startCnt <= startCnt + 16'd1;
          end
        end

        ST_WAIT_LOW: begin
          if (atLimit) begin
            state      <= ST_ERROR;
            TimeoutErr <= 1'b1;
            CycleCount <= MAX_CYCLES;
            Busy       <= 1'b0;
          end else if (!DutAck) begin
            state <= ST_WAIT_HIGH;
          end
        end

        // runCnt counts earlier wait cycles; +1 includes the Ack cycle itself.
        ST_WAIT_HIGH: begin
          if (atLimit) begin
            state      <= ST_ERROR;
            TimeoutErr <= 1'b1;
            CycleCount <= MAX_CYCLES;
            Busy       <= 1'b0;
          end else if (DutAck) begin
            state       <= ST_RECORD;
            CycleCount  <= runCnt + CYC_W'(1);
            ResultValid <= 1'b1;
          end
        end

        ST_RECORD: begin
          if (ProgIdx == LAST_IDX) begin
            state <= ST_DONE;
            Done  <= 1'b1;
            Busy  <= 1'b0;
          end else begin
            state    <= ST_START;
            startCnt <= '0;
            ProgIdx  <= ProgIdx + PW'(1);
            DutStart <= 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_launcher.sv
// tb_prog_launcher
//   Randomized self-checking bench. The bench plays the processor: for each
//   program it holds a stale Ack level for s wait cycles, drops Ack for L
//   cycles, then raises it (or never raises it). Expected results follow
//   from that plan alone: completion in wait cycle s+L+1 with that count,
//   unless it exceeds MAX_CYCLES, in which case a timeout in wait cycle
//   MAX_CYCLES+1 reporting MAX_CYCLES.
module tb_prog_launcher;

  localparam int          NP   = 3;
  localparam int          SL   = 4;
  localparam int          MAXC = 100;
  localparam int          PWB  = $clog2(NP) + 1;

  logic             Clk;
  logic             Reset;
  logic             Go;
  logic             DutStart;
  logic             DutAck;
  logic [PWB-1:0]   ProgIdx;
  logic [15:0]      CycleCount;
  logic             ResultValid;
  logic             Busy;
  logic             Done;
  logic             TimeoutErr;

  int vecCount = 0;
  int errCount = 0;

  // Per-program plan for the next sequence.
  int sA  [NP];
  int LA  [NP];
  bit stA [NP];
  bit hgA [NP];
  bit gpA [NP];

  prog_launcher #(
    .NUM_PROGS  (NP),
    .START_LEN  (SL),
    .MAX_CYCLES (16'(MAXC))
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Go          (Go),
    .DutStart    (DutStart),
    .DutAck      (DutAck),
    .ProgIdx     (ProgIdx),
    .CycleCount  (CycleCount),
    .ResultValid (ResultValid),
    .Busy        (Busy),
    .Done        (Done),
    .TimeoutErr  (TimeoutErr)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got=stuck required=finish");
    $fatal(1);
  end

  task automatic checkVal(input string tag, input longint got, input longint exp);
    vecCount++;
    if (got != exp) begin
      errCount++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, "_start"},  DutStart, 0);
    checkVal({tag, "_idx"},    ProgIdx, 0);
    checkVal({tag, "_count"},  CycleCount, 0);
    checkVal({tag, "_valid"},  ResultValid, 0);
    checkVal({tag, "_busy"},   Busy, 0);
    checkVal({tag, "_done"},   Done, 0);
    checkVal({tag, "_tmo"},    TimeoutErr, 0);
  endtask

  // Entered at the negedge of the first cycle with DutStart high.
  task automatic runProg(input int idx, input int s, input bit staleHigh,
                         input int L, input bit hang, input bit goPulse,
                         output bit timedOut);
    int cnt;
    int kEnd;
    bit expTo;
    cnt = 0;
    checkVal("start_idx", ProgIdx, idx);
    while (DutStart && cnt < 64) begin
      DutAck = 1'($urandom_range(0, 1));
      cnt++;
      @(negedge Clk);
    end
    checkVal("start_len", cnt, SL);
    if (hang || (s + L + 1 > MAXC)) begin
      expTo = 1'b1;
      kEnd  = MAXC + 1;
    end else begin
      expTo = 1'b0;
      kEnd  = s + L + 1;
    end
    for (int k = 1; k <= kEnd; k++) begin
      DutAck = (k <= s) ? staleHigh : ((k <= s + L) ? 1'b0 : !hang);
      Go     = goPulse && (k == s + L);
      @(negedge Clk);
      Go = 1'b0;
      if (k < kEnd) begin
        checkVal("early_result", ResultValid, 0);
        checkVal("early_tmo", TimeoutErr, 0);
        checkVal("run_busy", Busy, 1);
        checkVal("run_start", DutStart, 0);
      end
    end
    timedOut = expTo;
    if (expTo) begin
      checkVal("tmo_flag", TimeoutErr, 1);
      checkVal("tmo_count", CycleCount, MAXC);
      checkVal("tmo_no_result", ResultValid, 0);
      checkVal("tmo_start", DutStart, 0);
      checkVal("tmo_busy", Busy, 0);
    end else begin
      checkVal("res_valid", ResultValid, 1);
      checkVal("res_count", CycleCount, kEnd);
      checkVal("res_idx", ProgIdx, idx);
      checkVal("res_tmo", TimeoutErr, 0);
    end
  endtask

  task automatic runSeq();
    bit to;
    bit stop;
    stop   = 1'b0;
    DutAck = 1'b1;
    Go     = 1'b1;
    @(negedge Clk);
    Go = 1'b0;
    checkVal("go_start", DutStart, 1);
    checkVal("go_done_clr", Done, 0);
    checkVal("go_tmo_clr", TimeoutErr, 0);
    checkVal("go_idx", ProgIdx, 0);
    checkVal("go_busy", Busy, 1);
    for (int i = 0; i < NP; i++) begin
      if (!stop) begin
        runProg(i, sA[i], stA[i], LA[i], hgA[i], gpA[i], to);
        if (to) begin
          stop = 1'b1;
          repeat (3) begin
            DutAck = 1'($urandom_range(0, 1));
            @(negedge Clk);
            checkVal("err_start", DutStart, 0);
            checkVal("err_valid", ResultValid, 0);
            checkVal("err_tmo", TimeoutErr, 1);
          end
        end else begin
          @(negedge Clk);
          checkVal("pulse_len", ResultValid, 0);
          if (i < NP - 1) begin
            checkVal("next_start", DutStart, 1);
          end else begin
            checkVal("seq_done", Done, 1);
            checkVal("seq_busy", Busy, 0);
            checkVal("seq_start", DutStart, 0);
            checkVal("seq_idx", ProgIdx, NP - 1);
          end
        end
      end
    end
  endtask

  task automatic setProg(input int i, input int s, input bit st, input int L,
                         input bit hg, input bit gp);
    sA[i] = s; stA[i] = st; LA[i] = L; hgA[i] = hg; gpA[i] = gp;
  endtask

  initial begin
    bit to;
    int r;
    Reset  = 1'b1;
    Go     = 1'b0;
    DutAck = 1'b1;
    repeat (2) @(negedge Clk);
    checkAllZero("reset");
    Reset = 1'b0;
    @(negedge Clk);
    checkAllZero("idle");

    // Ack drops in the first wait cycle, rises after 20/35/7 low cycles.
    setProg(0, 0, 1'b0, 20, 1'b0, 1'b0);
    setProg(1, 0, 1'b0, 35, 1'b0, 1'b1);
    setProg(2, 0, 1'b0, 7,  1'b0, 1'b0);
    runSeq();

    // Stale Ack high for 5 wait cycles, low for 10, then high -> 16.
    setProg(0, 5, 1'b1, 10, 1'b0, 1'b0);
    setProg(1, 3, 1'b1, 1,  1'b0, 1'b0);
    setProg(2, 0, 1'b0, 99, 1'b0, 1'b0);
    repeat (2) @(negedge Clk);
    runSeq();

    // Program 1 never halts.
    setProg(0, 0, 1'b0, 12, 1'b0, 1'b0);
    setProg(1, 0, 1'b0, 4,  1'b1, 1'b0);
    setProg(2, 0, 1'b0, 4,  1'b0, 1'b0);
    runSeq();

    // Ack high through all of the wait phase, then Ack rising on the timeout cycle.
    setProg(0, 200, 1'b1, 1, 1'b0, 1'b0);
    runSeq();
    setProg(0, 0, 1'b0, 100, 1'b0, 1'b0);
    runSeq();

    // Reset while program 1 sits in WAIT_HIGH.
    setProg(0, 0, 1'b0, 5, 1'b0, 1'b0);
    DutAck = 1'b1;
    Go     = 1'b1;
    @(negedge Clk);
    Go = 1'b0;
    runProg(0, 0, 1'b0, 5, 1'b0, 1'b0, to);
    @(negedge Clk);
    checkVal("rst_pre_start", DutStart, 1);
    for (int c = 0; c < 64 && DutStart; c++) begin
      DutAck = 1'($urandom_range(0, 1));
      @(negedge Clk);
    end
    DutAck = 1'b0;
    repeat (3) @(negedge Clk);
    checkVal("rst_pre_idx", ProgIdx, 1);
    checkVal("rst_pre_busy", Busy, 1);
    #2 Reset = 1'b1;
    #1 checkAllZero("async_rst");
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    checkAllZero("post_rst");
    setProg(0, 2, 1'b0, 9,  1'b0, 1'b0);
    setProg(1, 1, 1'b1, 14, 1'b0, 1'b0);
    setProg(2, 0, 1'b0, 3,  1'b0, 1'b0);
    runSeq();

    // Randomized sequences, including both sides of the timeout boundary.
    repeat (20) begin
      for (int i = 0; i < NP; i++) begin
        sA[i]  = $urandom_range(0, 6);
        stA[i] = 1'($urandom_range(0, 1));
        hgA[i] = 1'b0;
        gpA[i] = ($urandom_range(0, 3) == 0);
        r = $urandom_range(0, 9);
        if (r == 0)      hgA[i] = 1'b1;
        if (r == 1)      LA[i]  = MAXC - sA[i];
        else if (r == 2) LA[i]  = MAXC - 1 - sA[i];
        else             LA[i]  = $urandom_range(1, 40);
      end
      repeat ($urandom_range(0, 3)) @(negedge Clk);
      runSeq();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
